// File: rtl/morse_pkg.sv
// morse_pkg: shared state, error-code and sizing definitions for the Morse character sequencer
package morse_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} seq_state_t;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_COL  = 2'd3;
    localparam int DEF_MAX_SYM = 5;
endpackage

// File: rtl/morse_gap_timer.sv
// morse_gap_timer: counts idle cycles while enabled and flags the cycle the gap reaches TIMEOUT
module morse_gap_timer #(
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TMR_W-1:0] cnt;
    assign expired = en && !clr && cnt == TMR_W'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (clr || !en) ? '0 : cnt + TMR_W'(1);
    end
endmodule

// File: rtl/morse_char_sequencer.sv
// morse_char_sequencer: packs dot/dash pulses into a Morse character presented on valid/ready
module morse_char_sequencer
    import morse_pkg::*;
#(
    parameter int MAX_SYM = DEF_MAX_SYM,
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dot_is,
    input  logic               dash_is,
    input  logic               space_is,
    input  logic               char_ready,
    output logic               char_valid,
    output logic [MAX_SYM-1:0] char_pattern,
    output logic [2:0]         char_len,
    output logic               busy,
    output logic               err,
    output logic [1:0]         err_code,
    output logic               overrun
);
    seq_state_t         state;
    logic [MAX_SYM-1:0] sr;
    logic [2:0]         len;
    logic               sym, col, expired, complete;
    assign sym      = dot_is | dash_is;
    assign col      = (dot_is & dash_is) | (space_is & sym);
    assign busy     = state == COLLECT;
    assign complete = busy && space_is && !col;
    morse_gap_timer #(.TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (sym | space_is),
        .en      (busy),
        .expired (expired)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sr           <= '0;
            len          <= '0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            char_valid   <= 1'b0;
            char_pattern <= '0;
            char_len     <= '0;
            overrun      <= 1'b0;
        end else begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
            if (col) begin
                err      <= 1'b1;
                err_code <= ERR_COL;
                sr       <= '0;
                len      <= '0;
                state    <= DISCARD;
            end else begin
                case (state)
                    IDLE: if (sym) begin
                        sr    <= MAX_SYM'(dash_is);
                        len   <= 3'd1;
                        state <= COLLECT;
                    end
                    COLLECT: if (sym && len == 3'(MAX_SYM)) begin
                        err      <= 1'b1;
                        err_code <= ERR_OVF;
                        sr       <= '0;
                        len      <= '0;
                        state    <= DISCARD;
                    end else if (sym) begin
                        sr[len] <= dash_is;
                        len     <= len + 3'd1;
                    end else if (space_is || expired) begin
                        err      <= expired;
                        err_code <= expired ? ERR_TMO : ERR_NONE;
                        sr       <= '0;
                        len      <= '0;
                        state    <= IDLE;
                    end
                    DISCARD: if (space_is) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            if (complete && (!char_valid || char_ready)) begin
                char_valid   <= 1'b1;
                char_pattern <= sr;
                char_len     <= len;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (char_valid && char_ready) begin
                char_valid <= 1'b0;
            end
        end
    end
endmodule
